cdf_scale_divider: RTL

Parametrised successor to the histogram-equalisation divider stage. It streams NUM_WORDS packed words of LANES cumulative-distribution values from scratch memory. Each lane computes y = ((x - cdf_min) * SCALE) / (total - cdf_min) with selectable truncate or round-to-nearest, and writes the packed results to a runtime destination region. It sits between the CDF accumulator and the pixel-remap stage and uses the same scratch-memory read/write ports.

---
 rtl/cdf_div_pkg.sv | 19 +
 rtl/cdf_scale_divider_lane.sv | 52 +++++
 rtl/cdf_scale_divider.sv | 112 +++++++++++
 3 files changed

// File: rtl/cdf_div_pkg.sv
// cdf_div_pkg: FSM encoding and width helpers shared by the CDF scale divider.
package cdf_div_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_CAP  = 3'd2;
    localparam logic [2:0] DIV     = 3'd3;
    localparam logic [2:0] WRITE   = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    function automatic int nw_of(input int dw, input int sw);
        return dw + sw;
    endfunction

    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/cdf_scale_divider_lane.sv
// cdf_lane_div: one lane of numerator prep, restoring division and saturation.
module cdf_lane_div
    import cdf_div_pkg::*;
#(
    parameter int DW    = 32,
    parameter int SW    = 8,
    parameter int SCALE = 255,
    parameter int ROUND = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [DW-1:0] x_i,
    input  logic [DW-1:0] cdf_min_i,
    input  logic [DW-1:0] total_i,
    input  logic [DW-1:0] denom_i,
    output logic [DW-1:0] res_o
);
    localparam int NW = nw_of(DW, SW);

    logic [NW-1:0] q_q, q_d, num, clamp;
    logic [DW-1:0] r_q, r_d;
    logic [DW:0]   r_sh;
    logic          sat_q, sat_d, ge;

    // q_q starts as the numerator and shifts into the quotient, one bit per step
    always_comb begin
        num   = (x_i > cdf_min_i) ? NW'(x_i - cdf_min_i) * NW'(SCALE) : '0;
        num   = num + ((ROUND != 0) ? NW'(denom_i >> 1) : '0);
        r_sh  = {r_q, q_q[NW-1]};
        ge    = r_sh >= {1'b0, denom_i};
        r_d   = load_i ? '0 : step_i ? DW'(ge ? r_sh - {1'b0, denom_i} : r_sh) : r_q;
        q_d   = load_i ? num : step_i ? {q_q[NW-2:0], ge} : q_q;
        sat_d = load_i ? (x_i >= total_i) : sat_q;
        clamp = (q_q > NW'(SCALE)) ? NW'(SCALE) : q_q;
        res_o = (denom_i == '0) ? '0 : sat_q ? DW'(SCALE) : DW'(clamp);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q   <= '0;
            r_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            r_q   <= r_d;
            sat_q <= sat_d;
        end
    end

endmodule

// File: rtl/cdf_scale_divider.sv
// cdf_scale_divider: streams packed CDF words, scales each lane to 0..SCALE, writes results back.
module cdf_scale_divider
    import cdf_div_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int AW    = 16,
    parameter int SCALE = 255,
    parameter int SW    = 8,
    parameter int ROUND = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DW-1:0]       cdf_min,
    input  logic [DW-1:0]       total,
    input  logic [AW-1:0]       src_base,
    input  logic [AW-1:0]       dst_base,
    input  logic [AW-1:0]       num_words,
    output logic [AW-1:0]       rd_addr,
    input  logic [LANES*DW-1:0] rd_data,
    output logic [AW-1:0]       wt_addr,
    output logic [LANES*DW-1:0] wt_data,
    output logic                wt_en,
    output logic                busy,
    output logic                rd_done,
    output logic                wt_done,
    output logic                div_zero_err
);
    localparam int NW = nw_of(DW, SW);
    localparam int CW = $clog2(NW);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, src_q, dst_q, num_q;
    logic [DW-1:0] min_q, tot_q, den_q;
    logic [CW-1:0] cnt_q;
    logic          err_q, last;

    assign last         = idx_q == num_q - AW'(1);
    assign rd_addr      = src_q + idx_q;
    assign wt_addr      = dst_q + idx_q;
    assign wt_en        = state_q == WRITE;
    assign busy         = state_q != IDLE;
    assign rd_done      = state_q == RD_CAP && last;
    assign wt_done      = wt_en && last;
    assign div_zero_err = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ((num_words == '0) ? DONE : RD_ADDR) : IDLE;
            RD_ADDR: state_d = RD_CAP;
            RD_CAP:  state_d = DIV;
            DIV:     state_d = (cnt_q == CW'(NW - 1)) ? WRITE : DIV;
            WRITE:   state_d = last ? DONE : RD_ADDR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            num_q   <= '0;
            min_q   <= '0;
            tot_q   <= '0;
            den_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == DIV) ? cnt_q + CW'(1) : '0;
            if (state_q == IDLE && start) begin
                idx_q <= '0;
                src_q <= src_base;
                dst_q <= dst_base;
                num_q <= num_words;
                min_q <= cdf_min;
                tot_q <= total;
                den_q <= (total > cdf_min) ? total - cdf_min : '0;
                err_q <= 1'b0;
            end
            if (state_q == WRITE) begin
                idx_q <= last ? idx_q : idx_q + AW'(1);
                err_q <= err_q | (den_q == '0);
            end
        end
    end

    // All lanes share the FSM's load/step strobes so they divide in lockstep
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cdf_lane_div #(
            .DW   (DW),
            .SW   (SW),
            .SCALE(SCALE),
            .ROUND(ROUND)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load_i   (state_q == RD_CAP),
            .step_i   (state_q == DIV),
            .x_i      (rd_data[lane_lsb(i, DW) +: DW]),
            .cdf_min_i(min_q),
            .total_i  (tot_q),
            .denom_i  (den_q),
            .res_o    (wt_data[lane_lsb(i, DW) +: DW])
        );
    end

endmodule
